rsa_keygen_param: RTL and testbench

- Parametrised RSA key-pair generator and next-generation key-setup block.
- Accepts primes p, q and public exponent e through a start/busy/done handshake.
- Computes n = p*q, phi_n = (p-1)(q-1) and private exponent d = e^-1 mod phi_n.
- Uses a sequential shift-add multiplier, then a multiply-free modular-accumulate search. It reports invalid operands and non-invertible e through err/err_code instead of hanging. It feeds the encrypt/decrypt datapath.

---
 rtl/rsa_keygen_param_pkg.sv | 18 +
 rtl/rsa_keygen_param_if.sv | 30 +++
 rtl/rsa_seq_mult.sv | 52 +++++
 rtl/rsa_keygen_param.sv | 148 ++++++++++++++
 tb/tb_rsa_keygen_param.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/rsa_keygen_param_pkg.sv
// Shared types for the RSA key-parameter generator.
// FSM state encoding and error codes reported with done.
package rsa_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULT,
    S_CHECK,
    S_SEARCH,
    S_DONE
  } state_t;

  localparam logic [1:0] ERR_OK     = 2'd0;
  localparam logic [1:0] ERR_BAD_PQ = 2'd1;
  localparam logic [1:0] ERR_BAD_E  = 2'd2;
  localparam logic [1:0] ERR_NO_INV = 2'd3;

endpackage

// File: rtl/rsa_keygen_param_if.sv
// Request/result bundle of the RSA key-parameter generator.
// master drives the request, slave is the generator.
interface rsa_keygen_param_if #(
  parameter int W  = 4,
  parameter int EW = 2*W
) ();

  logic             start;
  logic [W-1:0]     p;
  logic [W-1:0]     q;
  logic [EW-1:0]    e;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       err_code;
  logic [2*W-1:0]   n;
  logic [2*W-1:0]   phi_n;
  logic [2*W-1:0]   d;

  modport master (
    output start, p, q, e,
    input  busy, done, err, err_code, n, phi_n, d
  );

  modport slave (
    input  start, p, q, e,
    output busy, done, err, err_code, n, phi_n, d
  );

endinterface

// File: rtl/rsa_seq_mult.sv
// Shift-add multiplier: bit 0 is folded in at load, so done
// pulses exactly W cycles after start with prod valid.
module rsa_seq_mult #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] prod
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [2*W-1:0] mc;
  logic [W-1:0]   mp;
  logic [CW-1:0]  cnt;
  logic           run;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mc   <= '0;
      mp   <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
      prod <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mc   <= {{W{1'b0}}, a} << 1;
        mp   <= b >> 1;
        prod <= b[0] ? {{W{1'b0}}, a} : '0;
        cnt  <= CW'(1);
        run  <= 1'b1;
      end else if (run) begin
        if (mp[0])
          prod <= prod + mc;
        mc  <= mc << 1;
        mp  <= mp >> 1;
        cnt <= cnt + CW'(1);
        if (cnt == CW'(W-1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rsa_keygen_param.sv
// RSA key-parameter generator: n, phi_n and d = e^-1 mod phi_n
// via two sequential multipliers and a one-candidate-per-cycle search.
module rsa_keygen_param
  import rsa_pkg::*;
#(
  parameter int W  = 4,
  parameter int EW = 2*W
) (
  input  logic               clk,
  input  logic               reset,
  rsa_keygen_param_if.slave  bus
);

  localparam int DW = 2*W;

  state_t         state;
  state_t         state_nx;
  logic [EW-1:0]  e_q;
  logic [DW-1:0]  acc;
  logic [DW-1:0]  d_cand;
  logic [DW-1:0]  n_r;
  logic [DW-1:0]  phi_r;
  logic [DW-1:0]  d_r;
  logic           err_r;
  logic [1:0]     code_r;

  logic           bad_pq;
  logic           accept;
  logic           mult_start;
  logic           done_n;
  logic           done_phi;
  logic [DW-1:0]  prod_n;
  logic [DW-1:0]  prod_phi;
  logic           e_bad;
  logic           found;
  logic           last;
  logic [DW:0]    sum;
  logic [DW:0]    diff;
  logic [DW-1:0]  acc_nx;

  assign bad_pq     = (bus.p < W'(2)) || (bus.q < W'(2));
  assign accept     = (state == S_IDLE) && bus.start;
  assign mult_start = accept && !bad_pq;

  rsa_seq_mult #(.W(W)) u_mult_n (
    .clk   (clk),
    .reset (reset),
    .start (mult_start),
    .a     (bus.p),
    .b     (bus.q),
    .done  (done_n),
    .prod  (prod_n)
  );

  rsa_seq_mult #(.W(W)) u_mult_phi (
    .clk   (clk),
    .reset (reset),
    .start (mult_start),
    .a     (bus.p - W'(1)),
    .b     (bus.q - W'(1)),
    .done  (done_phi),
    .prod  (prod_phi)
  );

  // acc < phi_n and e < phi_n, so one conditional subtract wraps
  assign e_bad  = (e_q < EW'(2)) || (e_q >= phi_r);
  assign found  = (acc == DW'(1));
  assign last   = (d_cand == phi_r - DW'(1));
  assign sum    = {1'b0, acc} + {1'b0, e_q};
  assign diff   = sum - {1'b0, phi_r};
  assign acc_nx = (sum >= {1'b0, phi_r}) ? diff[DW-1:0] : sum[DW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    bus.busy     = (state != S_IDLE);
    bus.done     = (state == S_DONE);
    bus.err      = err_r;
    bus.err_code = code_r;
    bus.n        = n_r;
    bus.phi_n    = phi_r;
    bus.d        = d_r;
    unique case (state)
      S_IDLE:   if (bus.start) state_nx = bad_pq ? S_DONE : S_MULT;
      S_MULT:   if (done_n && done_phi) state_nx = S_CHECK;
      S_CHECK:  state_nx = e_bad ? S_DONE : S_SEARCH;
      S_SEARCH: if (found || last) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q    <= '0;
      acc    <= '0;
      d_cand <= '0;
      n_r    <= '0;
      phi_r  <= '0;
      d_r    <= '0;
      err_r  <= 1'b0;
      code_r <= ERR_OK;
    end else begin
      unique case (state)
        S_IDLE: if (bus.start) begin
          e_q    <= bus.e;
          n_r    <= '0;
          phi_r  <= '0;
          d_r    <= '0;
          err_r  <= bad_pq;
          code_r <= bad_pq ? ERR_BAD_PQ : ERR_OK;
        end
        S_MULT: if (done_n && done_phi) begin
          n_r   <= prod_n;
          phi_r <= prod_phi;
        end
        S_CHECK: begin
          if (e_bad) begin
            err_r  <= 1'b1;
            code_r <= ERR_BAD_E;
          end else begin
            acc    <= e_q;
            d_cand <= DW'(1);
          end
        end
        S_SEARCH: begin
          if (found) begin
            d_r <= d_cand;
          end else if (last) begin
            err_r  <= 1'b1;
            code_r <= ERR_NO_INV;
          end else begin
            d_cand <= d_cand + DW'(1);
            acc    <= acc_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_keygen_param.sv
// Directed bench for rsa_keygen_param at W=4 and W=8.
// Expected values are hand-computed RSA parameters.
module tb_rsa_keygen_param;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  rsa_keygen_param_if #(.W(4)) if4 ();
  rsa_keygen_param_if #(.W(8)) if8 ();

  rsa_keygen_param #(.W(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (if4)
  );

  rsa_keygen_param #(.W(8)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (if8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // accept on the next edge, then count cycles until done
  task automatic run4(input string tag,
                      input int p, input int q, input int e,
                      input int en, input int ephi, input int ed,
                      input int ecode, input int elat,
                      input int poke);
    int cyc;
    int busy_low;
    cyc      = 0;
    busy_low = 0;
    if4.p     = 4'(p);
    if4.q     = 4'(q);
    if4.e     = 8'(e);
    if4.start = 1'b1;
    @(posedge clk);
    #1;
    if4.start = 1'b0;
    cyc = 1;
    while (!if4.done && cyc < 300) begin
      if (!if4.busy) busy_low++;
      if (cyc == poke) begin
        if4.p     = 4'd5;
        if4.q     = 4'd7;
        if4.e     = 8'd5;
        if4.start = 1'b1;
      end else begin
        if4.start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    if4.start = 1'b0;
    if (!if4.busy) busy_low++;
    chk({tag, "_lat"}, 64'(cyc), 64'(elat));
    chk({tag, "_busy"}, 64'(busy_low), 64'd0);
    chk({tag, "_n"}, 64'(if4.n), 64'(en));
    chk({tag, "_phi"}, 64'(if4.phi_n), 64'(ephi));
    chk({tag, "_d"}, 64'(if4.d), 64'(ed));
    chk({tag, "_code"}, 64'(if4.err_code), 64'(ecode));
    chk({tag, "_err"}, 64'(if4.err), 64'(ecode != 0));
    @(posedge clk);
    #1;
    chk({tag, "_idle"}, 64'({if4.busy, if4.done}), 64'd0);
    chk({tag, "_hold"}, 64'(if4.d), 64'(ed));
  endtask

  initial begin
    int cyc;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    if4.start = 1'b0;
    if4.p = '0;
    if4.q = '0;
    if4.e = '0;
    if8.start = 1'b0;
    if8.p = '0;
    if8.q = '0;
    if8.e = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", 64'({if4.busy, if4.done, if4.err, if4.err_code}), 64'd0);
    chk("rst_val", 64'({if4.n, if4.phi_n, if4.d}), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run4("k3_11",   3, 11, 3, 33, 20, 7, 0, 13, 0);
    run4("k5_7",    5,  7, 5, 35, 24, 5, 0, 11, 0);
    run4("k3_5",    3,  5, 3, 15,  8, 3, 0,  9, 0);
    run4("noinv",   3,  7, 3, 21, 12, 0, 3, 17, 0);
    run4("bade_hi", 3,  3, 5,  9,  4, 0, 2,  6, 0);
    run4("badpq",   1,  7, 3,  0,  0, 0, 1,  1, 0);
    run4("bade_1",  3, 11, 1, 33, 20, 0, 2,  6, 0);
    run4("ignore",  3, 11, 3, 33, 20, 7, 0, 13, 3);

    if4.p     = 4'd3;
    if4.q     = 4'd11;
    if4.e     = 8'd3;
    if4.start = 1'b1;
    @(posedge clk);
    #1;
    if4.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("pre_rst_n", 64'(if4.n), 64'd33);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_ctl", 64'({if4.busy, if4.done, if4.err, if4.err_code}), 64'd0);
    chk("mid_rst_val", 64'({if4.n, if4.phi_n, if4.d}), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    run4("post_rst", 5, 7, 5, 35, 24, 5, 0, 11, 0);

    if8.p     = 8'd61;
    if8.q     = 8'd53;
    if8.e     = 16'd17;
    if8.start = 1'b1;
    @(posedge clk);
    #1;
    if8.start = 1'b0;
    cyc = 1;
    while (!if8.done && cyc < 4000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("w8_lat", 64'(cyc), 64'd2763);
    chk("w8_n", 64'(if8.n), 64'd3233);
    chk("w8_phi", 64'(if8.phi_n), 64'd3120);
    chk("w8_d", 64'(if8.d), 64'd2753);
    chk("w8_err", 64'({if8.err, if8.err_code}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
